// File: rtl/tmds_link_sequencer.sv
// tmds_link_sequencer
// Brings up and supervises the TMDS serializer / PAL-NTSC diplexer path in
// the clk_pixel domain. The serializer is held in reset until the PLL lock
// has been stable for LOCK_STABLE_CYCLES. The link is released on a frame
// boundary. Mode changes are applied only after a drain and a full re-lock.
//
// Ports:
//   clk_pixel        pixel clock, sole clock
//   reset            synchronous active-high reset
//   pll_locked       asynchronous PLL lock, 2-flop synchronised here
//   frame_start      1-cycle pulse at the first pixel of a frame
//   pal_mode_req     requested mode level (1 = PAL, 0 = NTSC)
//   pal_mode         registered mode select to the diplexer
//   serializer_reset reset to the serializer
//   tmds_blank       1 = encoders emit control-period symbols only
//   link_up          1 only in ACTIVE
//   lock_loss_count  saturating count of lock losses outside RESET_HOLD
//   state_dbg        current state encoding
module tmds_link_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SER_RESET_CYCLES   = 16,
  parameter int SETTLE_CYCLES      = 256,
  parameter int DRAIN_CYCLES       = 64
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       frame_start,
  input  logic       pal_mode_req,
  output logic       pal_mode,
  output logic       serializer_reset,
  output logic       tmds_blank,
  output logic       link_up,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam int MAX_A = (LOCK_STABLE_CYCLES > SER_RESET_CYCLES) ? LOCK_STABLE_CYCLES : SER_RESET_CYCLES;
  localparam int MAX_B = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // Terminal counts: the counter runs 0..N-1, so N cycles are spent per state.
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SER_LAST    = CW'(SER_RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    SER_RESET  = 3'd1,
    SETTLE     = 3'd2,
    WAIT_FRAME = 3'd3,
    ACTIVE     = 3'd4,
    DRAIN      = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lock_meta, lock_s;
  logic          lock_lost;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CW'(1);
    lock_lost = 1'b0;
    case (state)
      RESET_HOLD: begin
        // Any dropout restarts the stability qualification from zero.
        if (!lock_s) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = SER_RESET;
          cnt_nx   = '0;
        end
      end
      SER_RESET: begin
        if (cnt == SER_LAST) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nx = WAIT_FRAME;
          cnt_nx   = '0;
        end
      end
      WAIT_FRAME: begin
        cnt_nx = '0;
        if (frame_start) state_nx = ACTIVE;
      end
      ACTIVE: begin
        cnt_nx = '0;
        // Mode changes only take effect on a frame boundary.
        if (frame_start && (pal_mode_req != pal_mode)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = RESET_HOLD;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = RESET_HOLD;
        cnt_nx   = '0;
      end
    endcase
    // Lock loss overrides every other transition.
    if (state != RESET_HOLD && !lock_s) begin
      state_nx  = RESET_HOLD;
      cnt_nx    = '0;
      lock_lost = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_meta        <= 1'b0;
      lock_s           <= 1'b0;
      state            <= RESET_HOLD;
      cnt              <= '0;
      pal_mode         <= 1'b0;
      serializer_reset <= 1'b1;
      tmds_blank       <= 1'b1;
      link_up          <= 1'b0;
      lock_loss_count  <= 8'd0;
    end else begin
      lock_meta        <= pll_locked;
      lock_s           <= lock_meta;
      state            <= state_nx;
      cnt              <= cnt_nx;
      // Outputs are decoded from the next state so they line up with state.
      serializer_reset <= (state_nx == RESET_HOLD) || (state_nx == SER_RESET);
      tmds_blank       <= (state_nx != ACTIVE);
      link_up          <= (state_nx == ACTIVE);
      // The mode only tracks the request while the serializer is held off.
      if (state == RESET_HOLD) pal_mode <= pal_mode_req;
      if (lock_lost && lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule
